// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the multi-channel reaction timer.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [31:0] FALSE_START = '1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_tick_gen.sv
// Millisecond tick prescaler; tick_o pulses once every TICK_DIV cycles, restarted by clr_i.
module reaction_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/reaction_timer_mc.sv
// Multi-channel reaction timer: random pre-delay, led stimulus, per-channel ms results and winner.
// Optional false-start detection during WAIT is enabled by defining EARLY_PRESS_DETECT_EN.
module reaction_timer_mc
  import reaction_timer_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CNT_W       = 14,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned MIN_WAIT_MS = 1000,
  parameter int unsigned RAND_W      = 11,
  parameter int unsigned TIMEOUT_MS  = 9999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_CH-1:0]       stop,
  input  logic                  clear,
  output logic                  led,
  output logic [N_CH*CNT_W-1:0] times,
  output logic [N_CH-1:0]       stopped,
  output logic [2:0]            winner,
  output logic                  timeout,
  output logic                  done_tick
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_MS);

  state_t            state_q, state_d;
  logic              start_q, clear_q;
  logic [N_CH-1:0]   stop_q;
  logic              start_ev, clear_ev;
  logic [N_CH-1:0]   stop_ev;
  logic [15:0]       lfsr_q;
  logic              ms_tick;
  logic              state_chg;
  logic [CNT_W-1:0]  cnt_q, cnt_inc, wait_q;
  logic [N_CH-1:0]   stopped_q, fs_q, hit;
  logic [2:0]        winner_q;
  logic              timeout_q, done_q;
  logic              round_start, tmo_hit, all_done, all_fs;

  function automatic logic [2:0] first_idx(input logic [N_CH-1:0] v);
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (v[i] && !found) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
      clear_q <= 1'b0;
      stop_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      start_q <= start;
      clear_q <= clear;
      stop_q  <= stop;
      lfsr_q  <= lfsr_step(lfsr_q);
    end
  end

  assign start_ev = start & ~start_q;
  assign clear_ev = clear & ~clear_q;
  assign stop_ev  = stop & ~stop_q;

  reaction_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_chg),
    .tick_o (ms_tick)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign round_start = start_ev && !clear_ev && (state_q == ST_IDLE || state_q == ST_DONE);
  assign tmo_hit     = (state_q == ST_RUN) && ms_tick && (cnt_inc >= TMO);
  assign hit         = stop_ev & ~stopped_q & ~fs_q & {N_CH{state_q == ST_RUN}};
  // False-started channels count as finished so the round can end without them.
  assign all_done    = &(stopped_q | fs_q | hit);
`ifdef EARLY_PRESS_DETECT_EN
  assign all_fs      = &(fs_q | (stop_ev & {N_CH{state_q == ST_WAIT}}));
`else
  assign all_fs      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_ev) state_d = ST_WAIT;
        ST_WAIT: begin
          if (all_fs)                              state_d = ST_DONE;
          else if (ms_tick && (cnt_inc >= wait_q)) state_d = ST_RUN;
        end
        ST_RUN:  if (tmo_hit || all_done) state_d = ST_DONE;
        ST_DONE: if (start_ev) state_d = ST_WAIT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      winner_q  <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_chg && (state_d == ST_DONE);
      if (state_chg) begin
        cnt_q <= '0;
      end else if (ms_tick && ((state_q == ST_WAIT) || (state_q == ST_RUN && cnt_q < TMO))) begin
        cnt_q <= cnt_inc;
      end
      if (round_start) begin
        wait_q <= CNT_W'(MIN_WAIT_MS) + CNT_W'(lfsr_q[RAND_W-1:0]);
      end
      if (clear_ev || round_start) begin
        winner_q  <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (tmo_hit) timeout_q <= 1'b1;
        if (stopped_q == '0 && |hit) winner_q <= first_idx(hit);
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] t_q;
    logic             st_q;
`ifdef EARLY_PRESS_DETECT_EN
    localparam logic [CNT_W-1:0] FS_VAL = FALSE_START[CNT_W-1:0];
    logic fs_ch_q;
`endif

    always_ff @(posedge clk) begin
      if (!reset || clear_ev || round_start) begin
        t_q  <= '0;
        st_q <= 1'b0;
`ifdef EARLY_PRESS_DETECT_EN
        fs_ch_q <= 1'b0;
`endif
      end else if (hit[k]) begin
        t_q  <= tmo_hit ? TMO : cnt_q;
        st_q <= 1'b1;
      end else if (tmo_hit && !st_q && !fs_q[k]) begin
        t_q <= TMO;
`ifdef EARLY_PRESS_DETECT_EN
      end else if (state_q == ST_WAIT && stop_ev[k] && !fs_ch_q) begin
        fs_ch_q <= 1'b1;
        t_q     <= FS_VAL;
`endif
      end
    end

`ifdef EARLY_PRESS_DETECT_EN
    assign fs_q[k] = fs_ch_q;
`else
    assign fs_q[k] = 1'b0;
`endif
    assign stopped_q[k]               = st_q;
    assign times[k*CNT_W +: CNT_W]    = t_q;
  end

  assign led       = (state_q == ST_RUN);
  assign stopped   = stopped_q;
  assign winner    = winner_q;
  assign timeout   = timeout_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_reaction_timer_mc.sv
// Randomized scoreboard bench for reaction_timer_mc (small tick/timeout parameters).
module tb_reaction_timer_mc;

  localparam int NCH = 2;
  localparam int CW  = 14;
  localparam int TD  = 4;
  localparam int TMO = 20;
  localparam int LIM = TMO * TD;

  typedef struct packed {
    logic [NCH*CW-1:0] times;
    logic [NCH-1:0]    stopped;
    logic [2:0]        winner;
    logic              timeout;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset, start, clear;
  logic [NCH-1:0]  stop;
  logic            led, timeout, done_tick;
  logic [NCH*CW-1:0] times;
  logic [NCH-1:0]  stopped;
  logic [2:0]      winner;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  reaction_timer_mc #(
    .N_CH(NCH), .CNT_W(CW), .TICK_DIV(TD), .MIN_WAIT_MS(3), .RAND_W(2), .TIMEOUT_MS(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .led(led), .times(times), .stopped(stopped), .winner(winner),
    .timeout(timeout), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Press at cycle j (1 = first edge after led rises) records whole ms elapsed before that edge.
  function automatic exp_t model(input int j0, input int j1, input bit early0);
    exp_t e;
    int   j[NCH];
    bit   fs[NCH];
    int   best;
    e = '0;
    j[0] = j0; j[1] = j1;
    fs[0] = 1'b0; fs[1] = 1'b0;
    if (early0) begin
      j[0] = 0;
`ifdef EARLY_PRESS_DETECT_EN
      fs[0] = 1'b1;
`endif
    end
    best = -1;
    for (int k = 0; k < NCH; k++) begin
      if (fs[k]) begin
        e.times[k*CW +: CW] = '1;
      end else if (j[k] > 0 && j[k] <= LIM) begin
        e.stopped[k]        = 1'b1;
        e.times[k*CW +: CW] = (j[k] < LIM) ? CW'((j[k] - 1) / TD) : CW'(TMO);
        if (best < 0 || j[k] < j[best]) best = k;
      end else begin
        e.times[k*CW +: CW] = CW'(TMO);
      end
      if (!fs[k] && !(j[k] > 0 && j[k] < LIM)) e.timeout = 1'b1;
    end
    e.winner = (best < 0) ? 3'd0 : 3'(best);
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && done_tick) begin
      chk("done_single_pulse", prev_done, 1'b0);
      chk("led_off_in_done", led, 1'b0);
      chk("done_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("times", times, e.times);
        chk("stopped", stopped, e.stopped);
        chk("winner", winner, e.winner);
        chk("timeout", timeout, e.timeout);
      end
    end
    prev_done = done_tick;
  end

  // Starts a round and returns at the negedge where led is first seen high.
  task automatic begin_round(input bit early0);
    int c;
    bit ok;
    start = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (early0 && c == 2) stop[0] = 1'b1;
    end while (!led && c < 200);
    chk("led_rise", led, 1'b1);
    ok = ((c - 1) % TD == 0) && (c >= 3 * TD + 1) && (c <= 6 * TD + 1);
    chk("wait_len_3to6ms", ok, 1'b1);
    start = 1'b0;
  endtask

  task automatic run_round(input int j0, input int j1, input bit early0);
    int  jj[NCH];
    bit  pulse_ok;
    sb.push_back(model(j0, j1, early0));
    jj[0] = early0 ? 0 : j0;
    jj[1] = j1;
    pulse_ok = (jj[0] == 0 || jj[0] > 2 || jj[1] == 0 || jj[1] > 2);
    begin_round(early0);
    for (int j = 1; j <= 100; j++) begin
      for (int k = 0; k < NCH; k++) begin
        if (jj[k] > 0) begin
          if (j == jj[k])     stop[k] = 1'b1;
          if (j == jj[k] + 2) stop[k] = 1'b0;
          if (j == jj[k] + 4) stop[k] = 1'b1;
        end
      end
      start = pulse_ok && (j == 2);
      @(negedge clk);
    end
    chk("round_finished", sb.size(), 0);
    stop  = '0;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int leds;
    int a, b;
    reset = 1'b0; start = 1'b0; clear = 1'b0; stop = '0;
    repeat (2) @(negedge clk);
    chk("rst_led", led, 1'b0);
    chk("rst_times", times, '0);
    chk("rst_stopped", stopped, '0);
    chk("rst_winner", winner, '0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_done", done_tick, 1'b0);
    chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
    reset = 1'b1;
    leds = 0;
    repeat (20) begin @(negedge clk); leds += int'(led); end
    chk("idle_led_low", leds, 0);

    run_round(29, 21, 1'b0);
    run_round(17, 17, 1'b0);
    run_round(0, 0, 1'b0);
    run_round(80, 3, 1'b0);
    run_round(81, 40, 1'b0);

    // Clear with a simultaneous stop must win and suppress the round end.
    begin_round(1'b0);
    for (int j = 1; j <= 9; j++) begin
      if (j == 5) stop[1] = 1'b1;
      if (j == 9) begin clear = 1'b1; stop[0] = 1'b1; end
      @(negedge clk);
    end
    chk("clr_times", times, '0);
    chk("clr_stopped", stopped, '0);
    chk("clr_led", led, 1'b0);
    chk("clr_winner", winner, '0);
    clear = 1'b0; stop = '0;
    leds = 0;
    repeat (30) begin @(negedge clk); leds += int'(led); end
    chk("clr_idle_led_low", leds, 0);

    run_round(0, 13, 1'b1);

    for (int r = 0; r < 10; r++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 88));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 88));
      if ($urandom_range(0, 3) == 0) b = a;
      run_round(a, b, 1'b0);
    end

    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
